// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM states and parity-mode encodings.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5
    } uart_state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: counts 0..divisor and pulses tick on the terminal count.
module uart_baud_tick #(
    parameter int DIV_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             clear,
    input  logic [DIV_W-1:0] divisor,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    // >= lets a divisor lowered while idle recover without a full wrap
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt <= '0;
        end else if (clear || (cnt >= divisor)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == divisor) && !clear;

endmodule

// File: rtl/rx_uart_cfg.sv
// Configurable oversampling UART receiver with majority-vote sampling, parity/framing/break
// detection and a one-word output holding register with overrun flag.
module rx_uart_cfg
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int OVS    = 16,
    parameter int DIV_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_Rx,
    input  logic [DIV_W-1:0]  i_baud_div,
    input  logic [1:0]        i_parity,
    input  logic              i_stop2,
    input  logic              i_ready,
    input  logic              i_ovr_clr,
    output logic [DATA_W-1:0] o_Data,
    output logic              o_valid,
    output logic              o_parity_err,
    output logic              o_frame_err,
    output logic              o_break,
    output logic              o_overrun,
    output logic              o_busy
);

    localparam int SW = $clog2(OVS);
    localparam int BW = $clog2(DATA_W);
    localparam logic [SW-1:0] SMP_A   = SW'(OVS/2 - 1);
    localparam logic [SW-1:0] SMP_B   = SW'(OVS/2);
    localparam logic [SW-1:0] SMP_C   = SW'(OVS/2 + 1);
    localparam logic [SW-1:0] SMP_END = SW'(OVS - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic              rx_s1, rx_s2, rx;
    uart_state_t       state, state_nxt;
    logic              armed;
    logic [1:0]        par_q;
    logic              stop2_q;
    logic [DIV_W-1:0]  div_q;
    logic              tick, start_det, done;
    logic [SW-1:0]     smp_cnt;
    logic [BW-1:0]     bit_cnt;
    logic              s0, s1;
    logic [DATA_W-1:0] shreg;
    logic              par_acc, zero_acc, perr_acc, ferr_acc;
    logic              at_a, at_b, decide, bit_end, bit_val, par_en;
    logic              brk_now, ferr_now, handshake;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= i_Rx;
            rx_s2 <= rx_s1;
        end
    end
    assign rx = rx_s2;

    uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .clear   (start_det),
        .divisor (div_q),
        .tick    (tick)
    );

    assign at_a    = tick && (smp_cnt == SMP_A);
    assign at_b    = tick && (smp_cnt == SMP_B);
    assign decide  = tick && (smp_cnt == SMP_C);
    assign bit_end = tick && (smp_cnt == SMP_END);
    assign bit_val = maj3(s0, s1, rx);
    assign par_en  = (par_q == PAR_EVEN) || (par_q == PAR_ODD);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start_det) state_nxt = ST_START;
            ST_START: begin
                if (decide && bit_val)  state_nxt = ST_IDLE;
                else if (bit_end)       state_nxt = ST_DATA;
            end
            ST_DATA:   if (bit_end && (bit_cnt == BIT_LAST))
                           state_nxt = par_en ? ST_PARITY : ST_STOP1;
            ST_PARITY: if (bit_end) state_nxt = ST_STOP1;
            ST_STOP1: begin
                if (decide && !stop2_q) state_nxt = ST_IDLE;
                else if (bit_end)       state_nxt = ST_STOP2;
            end
            ST_STOP2:  if (decide) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_busy    = (state != ST_IDLE);
        start_det = (state == ST_IDLE) && !rx && armed;
        done      = decide && (((state == ST_STOP1) && !stop2_q) || (state == ST_STOP2));
    end

    // armed blocks a still-low line (break) from retriggering until it has gone high again
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            armed   <= 1'b0;
            par_q   <= PAR_NONE;
            stop2_q <= 1'b0;
            div_q   <= '0;
            smp_cnt <= '0;
            bit_cnt <= '0;
        end else begin
            if (done)
                armed <= 1'b0;
            else if ((state == ST_IDLE) && rx)
                armed <= 1'b1;
            if (start_det) begin
                par_q   <= i_parity;
                stop2_q <= i_stop2;
                div_q   <= i_baud_div;
                bit_cnt <= '0;
            end else if ((state == ST_DATA) && bit_end) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (state == ST_IDLE)
                smp_cnt <= '0;
            else if (tick)
                smp_cnt <= (smp_cnt == SMP_END) ? '0 : smp_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (start_det) begin
            par_acc  <= 1'b0;
            zero_acc <= 1'b1;
            perr_acc <= 1'b0;
            ferr_acc <= 1'b0;
        end
        if (at_a) s0 <= rx;
        if (at_b) s1 <= rx;
        if (decide) begin
            case (state)
                ST_DATA: begin
                    shreg    <= {bit_val, shreg[DATA_W-1:1]};
                    par_acc  <= par_acc ^ bit_val;
                    zero_acc <= zero_acc & ~bit_val;
                end
                ST_PARITY: begin
                    perr_acc <= (par_q == PAR_ODD) ? ~(par_acc ^ bit_val) : (par_acc ^ bit_val);
                    zero_acc <= zero_acc & ~bit_val;
                end
                ST_STOP1, ST_STOP2: begin
                    ferr_acc <= ferr_acc | ~bit_val;
                    zero_acc <= zero_acc & ~bit_val;
                end
                default: ;
            endcase
        end
    end

    assign brk_now   = zero_acc & ~bit_val;
    assign ferr_now  = ferr_acc | ~bit_val | brk_now;
    assign handshake = o_valid && i_ready;

    // Output holding register: a new word replaces the held one only if it is being consumed
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_Data       <= '0;
            o_valid      <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_break      <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            if (done && (!o_valid || handshake)) begin
                o_Data       <= shreg;
                o_valid      <= 1'b1;
                o_parity_err <= perr_acc;
                o_frame_err  <= ferr_now;
                o_break      <= brk_now;
            end else if (handshake) begin
                o_valid <= 1'b0;
            end
            if (done && o_valid && !handshake)
                o_overrun <= 1'b1;
            else if (i_ovr_clr)
                o_overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rx_uart_cfg.sv
// Directed bench for rx_uart_cfg: table of frames on an 8-bit instance plus hand-written
// sequences for false start, break, overrun and a 9-bit two-stop instance with mid-frame reset.
module tb_rx_uart_cfg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst8, rx8, stop2_8, ready8, ovr_clr8;
    logic [15:0] div8;
    logic [1:0]  par8;
    logic [7:0]  data8;
    logic        valid8, perr8, ferr8, brk8, ovr8, busy8;

    logic        rst9, rx9, stop2_9, ready9, ovr_clr9;
    logic [15:0] div9;
    logic [1:0]  par9;
    logic [8:0]  data9;
    logic        valid9, perr9, ferr9, brk9, ovr9, busy9;

    rx_uart_cfg #(.DATA_W(8), .OVS(16), .DIV_W(16)) dut8 (
        .i_clk(clk), .i_rst(rst8), .i_Rx(rx8), .i_baud_div(div8), .i_parity(par8),
        .i_stop2(stop2_8), .i_ready(ready8), .i_ovr_clr(ovr_clr8),
        .o_Data(data8), .o_valid(valid8), .o_parity_err(perr8), .o_frame_err(ferr8),
        .o_break(brk8), .o_overrun(ovr8), .o_busy(busy8)
    );

    rx_uart_cfg #(.DATA_W(9), .OVS(16), .DIV_W(16)) dut9 (
        .i_clk(clk), .i_rst(rst9), .i_Rx(rx9), .i_baud_div(div9), .i_parity(par9),
        .i_stop2(stop2_9), .i_ready(ready9), .i_ovr_clr(ovr_clr9),
        .o_Data(data9), .o_valid(valid9), .o_parity_err(perr9), .o_frame_err(ferr9),
        .o_break(brk9), .o_overrun(ovr9), .o_busy(busy9)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       prev8 = 1'b0, prev9 = 1'b0;
    int         vcnt8 = 0, vcnt9 = 0, rise8 = 0;
    logic [7:0] cd8;
    logic [8:0] cd9;
    logic       cp8, cf8, cb8, cp9, cf9, cb9;

    always @(negedge clk) begin
        prev8 <= valid8;
        if (valid8 && !prev8) begin
            vcnt8 <= vcnt8 + 1;
            rise8 <= cyc;
            cd8   <= data8;
            cp8   <= perr8;
            cf8   <= ferr8;
            cb8   <= brk8;
        end
    end

    always @(negedge clk) begin
        prev9 <= valid9;
        if (valid9 && !prev9) begin
            vcnt9 <= vcnt9 + 1;
            cd9   <= data9;
            cp9   <= perr9;
            cf9   <= ferr9;
            cb9   <= brk9;
        end
    end

    task automatic drive_bit(input bit sel9, input logic v, input int cpb);
        if (sel9) rx9 = v;
        else      rx8 = v;
        repeat (cpb) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input bit sel9, input logic [8:0] d, input int nbits,
                              input bit use_par, input logic pbit, input logic stopv,
                              input int nstop, input int cpb, input int tail);
        drive_bit(sel9, 1'b0, cpb);
        for (int i = 0; i < nbits; i++) drive_bit(sel9, d[i], cpb);
        if (use_par) drive_bit(sel9, pbit, cpb);
        for (int i = 0; i < nstop; i++) drive_bit(sel9, stopv, cpb);
        if (tail > 0) drive_bit(sel9, 1'b1, tail);
    endtask

    typedef struct {
        logic [7:0] data;
        logic [1:0] par;
        logic       send_par;
        logic       pbit;
        logic       stopv;
        logic [7:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
        logic       exp_brk;
    } vec_t;

    vec_t vt[12];

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base, t0;

        vt[0]  = '{8'hA5, 2'b00, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
        vt[1]  = '{8'h03, 2'b01, 1'b1, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0, 1'b0};
        vt[2]  = '{8'h03, 2'b01, 1'b1, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0};
        vt[3]  = '{8'h03, 2'b10, 1'b1, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0};
        vt[4]  = '{8'h5A, 2'b00, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0};
        vt[5]  = '{8'h3C, 2'b00, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0};
        vt[6]  = '{8'h00, 2'b01, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
        vt[7]  = '{8'h80, 2'b10, 1'b1, 1'b0, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0};
        vt[8]  = '{8'hFF, 2'b11, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};
        vt[9]  = '{8'h01, 2'b01, 1'b1, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0};
        vt[10] = '{8'h00, 2'b00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
        vt[11] = '{8'h81, 2'b10, 1'b1, 1'b0, 1'b1, 8'h81, 1'b1, 1'b0, 1'b0};

        rst8 = 1'b1; rx8 = 1'b1; div8 = 16'd0; par8 = 2'b00; stop2_8 = 1'b0;
        ready8 = 1'b1; ovr_clr8 = 1'b0;
        rst9 = 1'b1; rx9 = 1'b1; div9 = 16'd5; par9 = 2'b00; stop2_9 = 1'b1;
        ready9 = 1'b1; ovr_clr9 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", int'(valid8), 0);
        check("rst_data", int'(data8), 0);
        check("rst_busy", int'(busy8), 0);
        check("rst_overrun", int'(ovr8), 0);
        check("rst_flags", int'({perr8, ferr8, brk8}), 0);
        rst8 = 1'b0;
        rst9 = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        base = vcnt8;
        t0 = cyc;
        send_frame(1'b0, 9'h0A5, 8, 1'b0, 1'b0, 1'b1, 1, 16, 24);
        check("a5_latency", rise8 - t0, 157);
        check("a5_count", vcnt8 - base, 1);
        check("a5_data", int'(cd8), 'hA5);

        for (int i = 0; i < 12; i++) begin
            par8 = vt[i].par;
            base = vcnt8;
            send_frame(1'b0, {1'b0, vt[i].data}, 8, vt[i].send_par, vt[i].pbit, vt[i].stopv, 1, 16, 24);
            check($sformatf("vec%0d_count", i), vcnt8 - base, 1);
            check($sformatf("vec%0d_data", i), int'(cd8), int'(vt[i].exp_data));
            check($sformatf("vec%0d_perr", i), int'(cp8), int'(vt[i].exp_perr));
            check($sformatf("vec%0d_ferr", i), int'(cf8), int'(vt[i].exp_ferr));
            check($sformatf("vec%0d_brk", i), int'(cb8), int'(vt[i].exp_brk));
        end
        par8 = 2'b00;

        base = vcnt8;
        rx8 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx8 = 1'b1;
        check("false_start_busy_hi", int'(busy8), 1);
        repeat (12) @(posedge clk);
        #1;
        check("false_start_busy_lo", int'(busy8), 0);
        repeat (24) @(posedge clk);
        #1;
        check("false_start_no_valid", vcnt8 - base, 0);
        base = vcnt8;
        send_frame(1'b0, 9'h05A, 8, 1'b0, 1'b0, 1'b1, 1, 16, 24);
        check("after_false_count", vcnt8 - base, 1);
        check("after_false_data", int'(cd8), 'h5A);

        base = vcnt8;
        rx8 = 1'b0;
        repeat (192) @(posedge clk);
        #1;
        rx8 = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("break_count", vcnt8 - base, 1);
        check("break_data", int'(cd8), 0);
        check("break_brk", int'(cb8), 1);
        check("break_ferr", int'(cf8), 1);
        base = vcnt8;
        send_frame(1'b0, 9'h0C3, 8, 1'b0, 1'b0, 1'b1, 1, 16, 24);
        check("after_break_count", vcnt8 - base, 1);
        check("after_break_data", int'(cd8), 'hC3);

        ready8 = 1'b0;
        send_frame(1'b0, 9'h011, 8, 1'b0, 1'b0, 1'b1, 1, 16, 24);
        check("ovr_first_valid", int'(valid8), 1);
        check("ovr_first_data", int'(data8), 'h11);
        send_frame(1'b0, 9'h022, 8, 1'b0, 1'b0, 1'b1, 1, 16, 24);
        check("ovr_held_data", int'(data8), 'h11);
        check("ovr_held_valid", int'(valid8), 1);
        check("ovr_set", int'(ovr8), 1);
        ovr_clr8 = 1'b1;
        @(posedge clk);
        #1;
        ovr_clr8 = 1'b0;
        check("ovr_cleared", int'(ovr8), 0);

        fork
            send_frame(1'b0, 9'h044, 8, 1'b0, 1'b0, 1'b1, 1, 16, 24);
            begin
                repeat (156) @(posedge clk);
                #1;
                ready8 = 1'b1;
                @(posedge clk);
                #1;
                ready8 = 1'b0;
            end
        join
        check("hs_same_cycle_data", int'(data8), 'h44);
        check("hs_same_cycle_valid", int'(valid8), 1);
        check("hs_same_cycle_no_ovr", int'(ovr8), 0);

        fork
            send_frame(1'b0, 9'h055, 8, 1'b0, 1'b0, 1'b1, 1, 16, 24);
            begin
                repeat (156) @(posedge clk);
                #1;
                ovr_clr8 = 1'b1;
                @(posedge clk);
                #1;
                ovr_clr8 = 1'b0;
            end
        join
        check("set_beats_clr_ovr", int'(ovr8), 1);
        check("set_beats_clr_data", int'(data8), 'h44);
        ready8 = 1'b1;
        @(posedge clk);
        #1;
        check("drain_valid", int'(valid8), 0);
        ovr_clr8 = 1'b1;
        @(posedge clk);
        #1;
        ovr_clr8 = 1'b0;
        check("drain_ovr", int'(ovr8), 0);

        base = vcnt9;
        send_frame(1'b1, 9'h1FF, 9, 1'b0, 1'b0, 1'b1, 2, 96, 96);
        check("w9_count", vcnt9 - base, 1);
        check("w9_data", int'(cd9), 'h1FF);
        check("w9_flags", int'({cp9, cf9, cb9}), 0);

        base = vcnt9;
        drive_bit(1'b1, 1'b0, 96);
        drive_bit(1'b1, 1'b1, 96);
        drive_bit(1'b1, 1'b0, 96);
        drive_bit(1'b1, 1'b1, 96);
        drive_bit(1'b1, 1'b0, 96);
        rx9 = 1'b1;
        repeat (48) @(posedge clk);
        #1;
        check("w9_midframe_busy", int'(busy9), 1);
        rst9 = 1'b1;
        #2;
        check("w9_rst_busy_async", int'(busy9), 0);
        check("w9_rst_data", int'(data9), 0);
        check("w9_rst_valid", int'(valid9), 0);
        check("w9_rst_flags", int'({perr9, ferr9, brk9, ovr9}), 0);
        @(posedge clk);
        #1;
        rst9 = 1'b0;
        repeat (48 + 6 * 96 + 96) @(posedge clk);
        #1;
        check("w9_no_spurious", vcnt9 - base, 0);
        check("w9_idle_busy", int'(busy9), 0);
        check("w9_idle_data", int'(data9), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
